// File: rtl/pool2x2_if.sv
// Stream bundle for pool2x2_stage: raster input stream and pooled output stream.
// The slave modport is the pooling stage; the master modport is its environment.
interface pool2x2_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_addr
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_addr
  );
endinterface

// File: rtl/pool2x2_stage.sv
// Non-overlapping 2x2 pooling of an IN_W x IN_H raster stream into an (IN_W/2) x (IN_H/2) map.
// Max pooling by default; define POOL_AVG_EN for floor-average pooling (same ports and timing).
module pool2x2_stage #(
  parameter int IN_W = 6,
  parameter int IN_H = 6,
  parameter int DW   = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  pool2x2_if.slave  bus,
  output logic      busy,
  output logic      pool_done
);
  localparam int NOUT = IN_W * IN_H / 4;
  localparam int AW   = $clog2(NOUT);
  localparam int CW   = $clog2(IN_W);
  localparam int RW   = $clog2(IN_H);
  localparam int LW   = $clog2(IN_W / 2);
`ifdef POOL_AVG_EN
  localparam int HW   = DW + 1;
`else
  localparam int HW   = DW;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [AW-1:0]   out_idx;
  logic            last_accepted;
  logic [HW-1:0]   hreg;
  logic [HW-1:0]   lbuf [IN_W/2];
  logic [LW-1:0]   lidx;
  logic [HW-1:0]   h;
  logic [DW-1:0]   win;
  logic            accept, out_fire, win_done, frame_arm;

  assign frame_arm    = start && (state != RUN);
  assign bus.in_ready = (state == RUN) && !(bus.out_valid && !bus.out_ready) && !last_accepted;
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_fire     = bus.out_valid && bus.out_ready;
  assign win_done     = accept && col[0] && row[0];
  assign lidx         = LW'(col >> 1);
  assign busy         = (state == RUN);
  assign pool_done    = (state == DONE);

  // NOTE: outputs get a default at the top of every always_comb so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (out_fire && bus.out_addr == AW'(NOUT - 1)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

`ifdef POOL_AVG_EN
  logic [DW+1:0] sum4;

  always_comb begin
    h    = '0;
    sum4 = '0;
    h    = hreg + HW'(bus.in_data);
    sum4 = (DW+2)'(lbuf[lidx]) + (DW+2)'(h);
    win  = sum4[DW+1:2];
  end
`else
  always_comb begin
    h   = '0;
    win = '0;
    h   = (bus.in_data > hreg) ? bus.in_data : hreg;
    win = (lbuf[lidx] > h) ? lbuf[lidx] : h;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      col           <= '0;
      row           <= '0;
      out_idx       <= '0;
      last_accepted <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_addr  <= '0;
    end else begin
      if (frame_arm) begin
        col           <= '0;
        row           <= '0;
        out_idx       <= '0;
        last_accepted <= 1'b0;
      end else if (accept) begin
        if (col == CW'(IN_W - 1)) begin
          col <= '0;
          if (row == RW'(IN_H - 1)) begin
            row           <= '0;
            last_accepted <= 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
      // in_ready is low while an output is stalled, so a completed window never overwrites one.
      if (win_done) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= win;
        bus.out_addr  <= out_idx;
        out_idx       <= out_idx + 1'b1;
      end else if (out_fire) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

  // NOTE: pair register and half-row buffer are pure datapath; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (!col[0])     hreg       <= HW'(bus.in_data);
      else if (!row[0]) lbuf[lidx] <= h;
    end
  end
endmodule

// File: tb/tb_pool2x2_stage.sv
// Directed bench for pool2x2_stage: a per-frame reference model fills an expectation queue that a
// negedge compare process drains on every output handshake; literal pooled values pin the model.
module tb_pool2x2_stage;
  localparam int IN_W = 6;
  localparam int IN_H = 6;
  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int NPIX = IN_W * IN_H;
  localparam int NOUT = NPIX / 4;
  localparam int BUDGET = 200;

  logic clk = 1'b0;
  logic rst, start, busy, pool_done;

  pool2x2_if #(.DW(DW), .AW(AW)) bus();

  pool2x2_stage #(.IN_W(IN_W), .IN_H(IN_H), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus), .busy(busy), .pool_done(pool_done)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } exp_t;
  exp_t          exp_q[$];
  int            got_log[64];
  int            got_n, n_acc, n_checks, n_fail;
  logic [DW-1:0] ramp[NPIX];
  logic [DW-1:0] sat[NPIX];
  int            lit[NOUT];

  task automatic check(input string name, input int got, input int expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Reference: pool each 2x2 block of the frame directly from its four pixels.
  task automatic build_expected(input logic [DW-1:0] px[NPIX]);
    exp_q.delete();
    for (int pr = 0; pr < IN_H / 2; pr++)
      for (int pc = 0; pc < IN_W / 2; pc++) begin
        int b, v[4], m;
        exp_t e;
        b = 2 * pr * IN_W + 2 * pc;
        v[0] = px[b]; v[1] = px[b + 1]; v[2] = px[b + IN_W]; v[3] = px[b + IN_W + 1];
`ifdef POOL_AVG_EN
        m = (v[0] + v[1] + v[2] + v[3]) / 4;
`else
        m = v[0];
        for (int k = 1; k < 4; k++) if (v[k] > m) m = v[k];
`endif
        e.addr = pr * (IN_W / 2) + pc;
        e.data = m;
        exp_q.push_back(e);
      end
  endtask

  always @(negedge clk)
    if (!rst && bus.in_valid && bus.in_ready) n_acc++;

  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("out_data[%0d]", e.addr), int'(bus.out_data), e.data);
        check($sformatf("out_addr[%0d]", e.addr), int'(bus.out_addr), e.addr);
        if (got_n < 64) got_log[got_n] = int'(bus.out_data);
        got_n++;
      end
    end

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check({tag, "_in_ready"},  int'(bus.in_ready),  0);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_out_data"},  int'(bus.out_data),  0);
    check({tag, "_out_addr"},  int'(bus.out_addr),  0);
    check({tag, "_busy"},      int'(busy),          0);
    check({tag, "_pool_done"}, int'(pool_done),     0);
  endtask

  // Drives one frame; mid_start pulses start alongside that pixel, abort_at applies rst before it.
  task automatic run_frame(input logic [DW-1:0] px[NPIX], input int mid_start, input int abort_at);
    int n;
    build_expected(px);
    n_acc = 0;
    got_n = 0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("armed_busy", int'(busy), 1);
    check("armed_pool_done", int'(pool_done), 0);
    @(posedge clk); #1;
    for (int i = 0; i < NPIX; i++) begin
      if (i == abort_at) begin
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_reset_vals("abort");
        exp_q.delete();
        return;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = px[i];
      if (i == mid_start) start = 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        if (bus.in_ready) break;
        n++;
        if (n > BUDGET) begin
          check("input_timeout", i, -1);
          bus.in_valid = 1'b0;
          start = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (!pool_done && n < BUDGET) begin @(negedge clk); n++; end
    @(negedge clk);
    check("done_pool_done", int'(pool_done), 1);
    check("done_busy", int'(busy), 0);
    check("done_in_ready", int'(bus.in_ready), 0);
    check("inputs_consumed", n_acc, NPIX);
    check("outputs_left", exp_q.size(), 0);
  endtask

  task automatic stall_watch();
    int n;
    n = 0;
    while (!bus.out_valid && n < BUDGET) begin @(negedge clk); n++; end
    if (!bus.out_valid) begin
      check("stall_timeout", 0, 1);
    end else begin
      for (int k = 0; k < 5; k++) begin
        check("stall_data", int'(bus.out_data), lit[0]);
        check("stall_addr", int'(bus.out_addr), 0);
        check("stall_in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
      end
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
  endtask

  task automatic check_literals(input string tag);
    check({tag, "_count"}, got_n, NOUT);
    for (int k = 0; k < NOUT; k++)
      check($sformatf("%s_lit%0d", tag, k), got_log[k], lit[k]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; got_n = 0; n_acc = 0;
    for (int i = 0; i < NPIX; i++) begin
      ramp[i] = DW'(i);
      sat[i]  = '1;
    end
`ifdef POOL_AVG_EN
    lit = '{3, 5, 7, 15, 17, 19, 27, 29, 31};
`else
    lit = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
`endif
    rst = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_vals("reset");

    // Plain ramp
    run_frame(ramp, -1, -1);
    check_literals("ramp");

    // Output stalled for five cycles at the first window
    bus.out_ready = 1'b0;
    fork
      run_frame(ramp, -1, -1);
      stall_watch();
    join
    check_literals("stall");

    // Saturated inputs
    run_frame(sat, -1, -1);
    check("sat_count", got_n, NOUT);
    for (int k = 0; k < NOUT; k++) check($sformatf("sat%0d", k), got_log[k], 32'hFFFF);

    // Reset mid-frame, then a clean frame
    run_frame(ramp, -1, 20);
    run_frame(ramp, -1, -1);
    check_literals("after_rst");

    // start mid-frame is ignored; start after DONE runs another frame
    run_frame(ramp, 10, -1);
    check_literals("mid_start");
    run_frame(ramp, -1, -1);
    check_literals("second");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
